// File: rtl/ahb2apb_bridge_if.sv
// ahb2apb_bridge_if: AHB-Lite slave side and APB master side signals of the bridge
interface ahb2apb_bridge_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
  logic              hsel;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [ADDR_W:0]   haddr;
  logic [DATA_W-1:0] hwdata;
  logic              hready_out;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;
  logic              psel1;
  logic              psel2;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic [DATA_W-1:0] prdata1;
  logic [DATA_W-1:0] prdata2;
  modport slave (
    input  hsel, htrans, hwrite, haddr, hwdata, pready, prdata1, prdata2,
    output hready_out, hresp, hrdata, psel1, psel2, penable, pwrite, paddr, pwdata
  );
  modport master (
    output hsel, htrans, hwrite, haddr, hwdata, pready, prdata1, prdata2,
    input  hready_out, hresp, hrdata, psel1, psel2, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: single-outstanding AHB-Lite to two-slave APB bridge, all outputs registered
// Optional APB_TIMEOUT_EN adds an ACCESS timeout that answers with a two-cycle AHB ERROR.
module ahb2apb_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input logic pclk,
  input logic preset,
  ahb2apb_bridge_if.slave bus
);
`ifdef APB_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  typedef enum logic [1:0] {IDLE, WDATA, SETUP, ACCESS} state_t;
`endif
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, hrdata_q, hrdata_d;
  logic wr_q, wr_d, sel_q, sel_d;
  logic psel1_q, psel1_d, psel2_q, psel2_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic hready_q, hready_d, hresp_q, hresp_d;
  // APB outputs lag the state by one edge: SETUP raises psel, ACCESS raises penable
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    sel_d     = sel_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    hrdata_d  = hrdata_q;
    psel1_d   = psel1_q;
    psel2_d   = psel2_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    hready_d  = hready_q;
    hresp_d   = hresp_q;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: if (bus.hsel && bus.htrans[1]) begin
        addr_d   = bus.haddr[ADDR_W-1:0];
        sel_d    = bus.haddr[ADDR_W];
        wr_d     = bus.hwrite;
        hready_d = 1'b0;
        state_d  = bus.hwrite ? WDATA : SETUP;
      end
      WDATA: begin
        pwdata_d = bus.hwdata;
        state_d  = SETUP;
      end
      SETUP: begin
        psel1_d  = !sel_q;
        psel2_d  = sel_q;
        paddr_d  = addr_q;
        pwrite_d = wr_q;
`ifdef APB_TIMEOUT_EN
        cnt_d    = '0;
`endif
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (!penable_q) penable_d = 1'b1;
        else if (bus.pready) begin
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
          hready_d  = 1'b1;
          hrdata_d  = wr_q ? hrdata_q : (sel_q ? bus.prdata2 : bus.prdata1);
          state_d   = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == TO) begin
            psel1_d   = 1'b0;
            psel2_d   = 1'b0;
            penable_d = 1'b0;
            hresp_d   = 1'b1;
            state_d   = ERR1;
          end
        end
`endif
      end
`ifdef APB_TIMEOUT_EN
      ERR1: begin
        hready_d = 1'b1;
        state_d  = ERR2;
      end
      ERR2: begin
        hresp_d = 1'b0;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pclk) begin
    if (!preset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      sel_q     <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      hready_q  <= 1'b1;
      hresp_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      sel_q     <= sel_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      hrdata_q  <= hrdata_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end
  assign bus.hready_out = hready_q;
  assign bus.hresp      = hresp_q;
  assign bus.hrdata     = hrdata_q;
  assign bus.psel1      = psel1_q;
  assign bus.psel2      = psel2_q;
  assign bus.penable    = penable_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
endmodule
